aux_bus_arbiter: RTL and testbench

Two-master arbiter for the 8-bit/16-bit-address auxiliary bus. It sits between the risc16f84 core's aux port (master 0) and a second aux master (master 1, e.g. a debug/host loader), and drives the single aux slave port (aux RAM / peripherals). Round-robin grant, registered single-beat transfers, and an optional bounded bus lock let either master do atomic read-modify-write sequences.

---
 rtl/aux_bus_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_aux_bus_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aux_bus_arbiter.sv
// aux_bus_arbiter: two-master round-robin arbiter for the aux bus with
// registered single-beat transfers and a bounded bus lock for RMW.
// Ports: clk_i, reset_i (sync, active high);
//   mN_req_i/we_i/lock_i/adr_i/dat_i from master N, mN_ack_o/dat_o back;
//   aux_adr_o/aux_dat_o/aux_we_o/aux_re_o to the slave, aux_dat_i from it.
module aux_bus_arbiter #(
   parameter int AUX_ADDR_WIDTH = 16,
   parameter int AUX_DATA_WIDTH = 8,
   parameter int LOCK_MAX       = 4
) (
   input  logic                      clk_i,
   input  logic                      reset_i,
   input  logic                      m0_req_i,
   input  logic                      m0_we_i,
   input  logic                      m0_lock_i,
   input  logic [AUX_ADDR_WIDTH-1:0] m0_adr_i,
   input  logic [AUX_DATA_WIDTH-1:0] m0_dat_i,
   output logic                      m0_ack_o,
   output logic [AUX_DATA_WIDTH-1:0] m0_dat_o,
   input  logic                      m1_req_i,
   input  logic                      m1_we_i,
   input  logic                      m1_lock_i,
   input  logic [AUX_ADDR_WIDTH-1:0] m1_adr_i,
   input  logic [AUX_DATA_WIDTH-1:0] m1_dat_i,
   output logic                      m1_ack_o,
   output logic [AUX_DATA_WIDTH-1:0] m1_dat_o,
   output logic [AUX_ADDR_WIDTH-1:0] aux_adr_o,
   output logic [AUX_DATA_WIDTH-1:0] aux_dat_o,
   input  logic [AUX_DATA_WIDTH-1:0] aux_dat_i,
   output logic                      aux_we_o,
   output logic                      aux_re_o
);

   typedef enum logic [1:0] {
      IDLE,
      XFER,
      ACK
   } state_t;

   localparam logic [3:0] LOCK_LIM = 4'(LOCK_MAX);

   state_t state, state_n;

   logic gnt, gnt_n;
   logic last, last_n;
   logic own_vld, own_vld_n;
   logic owner, owner_n;
   // lock_i of the granted transfer, frozen at grant
   logic lock, lock_n;
   logic [3:0] lock_cnt, lock_cnt_n;

   logic [AUX_ADDR_WIDTH-1:0] adr_n;
   logic [AUX_DATA_WIDTH-1:0] dat_n;
   logic [AUX_DATA_WIDTH-1:0] d0_n;
   logic [AUX_DATA_WIDTH-1:0] d1_n;
   logic we_n, re_n, ack0_n, ack1_n;

   logic go, pick, pick_we;
   logic own_req, own_lock;

   assign own_req  = owner ? m1_req_i : m0_req_i;
   assign own_lock = owner ? m1_lock_i : m0_lock_i;

   always_comb begin
      state_n    = state;
      gnt_n      = gnt;
      last_n     = last;
      own_vld_n  = own_vld;
      owner_n    = owner;
      lock_n     = lock;
      lock_cnt_n = lock_cnt;
      adr_n      = aux_adr_o;
      dat_n      = aux_dat_o;
      d0_n       = m0_dat_o;
      d1_n       = m1_dat_o;
      we_n       = 1'b0;
      re_n       = 1'b0;
      ack0_n     = 1'b0;
      ack1_n     = 1'b0;
      go         = 1'b0;
      pick       = 1'b0;
      pick_we    = 1'b0;

      unique case (state)
         IDLE: begin
            if (own_vld) begin
               // locked: only the owner may be granted; it releases
               // by idling with lock_i low
               if (own_req) begin
                  go   = 1'b1;
                  pick = owner;
               end else if (!own_lock) begin
                  own_vld_n  = 1'b0;
                  lock_cnt_n = '0;
               end
            end else if (m0_req_i && m1_req_i) begin
               go   = 1'b1;
               pick = ~last;
            end else if (m0_req_i) begin
               go   = 1'b1;
               pick = 1'b0;
            end else if (m1_req_i) begin
               go   = 1'b1;
               pick = 1'b1;
            end

            if (go) begin
               pick_we = pick ? m1_we_i : m0_we_i;
               state_n = XFER;
               gnt_n   = pick;
               adr_n   = pick ? m1_adr_i : m0_adr_i;
               dat_n   = pick ? m1_dat_i : m0_dat_i;
               lock_n  = pick ? m1_lock_i : m0_lock_i;
               we_n    = pick_we;
               re_n    = ~pick_we;
            end
         end

         XFER: begin
            state_n = ACK;
            if (aux_re_o) begin
               if (gnt) begin
                  d1_n = aux_dat_i;
               end else begin
                  d0_n = aux_dat_i;
               end
            end
            ack0_n = ~gnt;
            ack1_n = gnt;
         end

         ACK: begin
            state_n = IDLE;
            last_n  = gnt;
            // a lock that hits the count limit is dropped, and since
            // last = gnt the other master wins the next tie
            if (lock && (lock_cnt + 4'd1 < LOCK_LIM)) begin
               own_vld_n  = 1'b1;
               owner_n    = gnt;
               lock_cnt_n = lock_cnt + 4'd1;
            end else begin
               own_vld_n  = 1'b0;
               lock_cnt_n = '0;
            end
         end

         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state     <= IDLE;
         gnt       <= 1'b0;
         last      <= 1'b1;
         own_vld   <= 1'b0;
         owner     <= 1'b0;
         lock      <= 1'b0;
         lock_cnt  <= '0;
         aux_adr_o <= '0;
         aux_dat_o <= '0;
         aux_we_o  <= 1'b0;
         aux_re_o  <= 1'b0;
         m0_ack_o  <= 1'b0;
         m1_ack_o  <= 1'b0;
         m0_dat_o  <= '0;
         m1_dat_o  <= '0;
      end else begin
         state     <= state_n;
         gnt       <= gnt_n;
         last      <= last_n;
         own_vld   <= own_vld_n;
         owner     <= owner_n;
         lock      <= lock_n;
         lock_cnt  <= lock_cnt_n;
         aux_adr_o <= adr_n;
         aux_dat_o <= dat_n;
         aux_we_o  <= we_n;
         aux_re_o  <= re_n;
         m0_ack_o  <= ack0_n;
         m1_ack_o  <= ack1_n;
         m0_dat_o  <= d0_n;
         m1_dat_o  <= d1_n;
      end
   end

endmodule

// File: tb/tb_aux_bus_arbiter.sv
// tb_aux_bus_arbiter: scoreboard bench for aux_bus_arbiter with directed
// scenarios and randomized two-master traffic against a memory model.
module tb_aux_bus_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset_i;
   logic        mem_clr;
   logic        req  [2];
   logic        we   [2];
   logic        lck  [2];
   logic [15:0] adr  [2];
   logic [7:0]  wdat [2];

   logic        m0_ack, m1_ack;
   logic [7:0]  m0_rd, m1_rd;
   logic [15:0] aux_adr;
   logic [7:0]  aux_wd, aux_rd;
   logic        aux_we, aux_re;

   aux_bus_arbiter #(
      .AUX_ADDR_WIDTH(16),
      .AUX_DATA_WIDTH(8),
      .LOCK_MAX(4)
   ) dut (
      .clk_i(clk),
      .reset_i(reset_i),
      .m0_req_i(req[0]),
      .m0_we_i(we[0]),
      .m0_lock_i(lck[0]),
      .m0_adr_i(adr[0]),
      .m0_dat_i(wdat[0]),
      .m0_ack_o(m0_ack),
      .m0_dat_o(m0_rd),
      .m1_req_i(req[1]),
      .m1_we_i(we[1]),
      .m1_lock_i(lck[1]),
      .m1_adr_i(adr[1]),
      .m1_dat_i(wdat[1]),
      .m1_ack_o(m1_ack),
      .m1_dat_o(m1_rd),
      .aux_adr_o(aux_adr),
      .aux_dat_o(aux_wd),
      .aux_dat_i(aux_rd),
      .aux_we_o(aux_we),
      .aux_re_o(aux_re)
   );

   // slave: 256-byte RAM on the low address byte
   logic [7:0] smem [256];
   always @(posedge clk) begin
      if (mem_clr) begin
         for (int i = 0; i < 256; i++) smem[i] <= 8'h00;
      end else if (aux_we) begin
         smem[aux_adr[7:0]] <= aux_wd;
      end
   end
   assign aux_rd = smem[aux_adr[7:0]];

   int   cyc = 0;
   logic in_rst;
   always @(posedge clk) begin
      cyc    <= cyc + 1;
      in_rst <= reset_i;
   end

   typedef struct packed {
      logic        we;
      logic [15:0] adr;
      logic [7:0]  dat;
      logic [7:0]  rd;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];
   logic [7:0] ref_mem [logic [15:0]];

   int checks = 0;
   int errors = 0;

   int hist_m[$];
   int hist_c[$];
   int ackcnt[2];

   int exp_t3[$] = '{0, 1, 0, 1, 0, 1};
   int exp_t4[$] = '{0, 0, 0, 0, 1, 0, 1};
   int exp_t6[$] = '{0, 1};

   task automatic check_eq(input string n, input logic [63:0] act,
                           input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                  n, act, exp, cyc);
      end
   endtask

   function automatic logic [7:0] ref_rd(input logic [15:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
   endfunction

   task automatic push_exp(input int m, input logic w,
                           input logic [15:0] a, input logic [7:0] d);
      exp_t e;
      e.we  = w;
      e.adr = a;
      e.dat = d;
      e.rd  = ref_rd(a);
      if (w) ref_mem[a] = d;
      if (m == 0) q0.push_back(e);
      else q1.push_back(e);
   endtask

   // issue one transfer from master m; call at a negedge, returns at
   // the negedge where the ack is seen
   task automatic xfer(input int m, input logic w, input logic l,
                       input logic [15:0] a, input logic [7:0] d,
                       output int lat);
      int  start;
      bit  got;
      push_exp(m, w, a, d);
      req[m]  = 1'b1;
      we[m]   = w;
      lck[m]  = l;
      adr[m]  = a;
      wdat[m] = d;
      start   = cyc;
      got     = 1'b0;
      for (int i = 0; i < 80 && !got; i++) begin
         @(negedge clk);
         if ((m == 0) ? m0_ack : m1_ack) got = 1'b1;
      end
      req[m] = 1'b0;
      lck[m] = 1'b0;
      lat    = cyc - start;
      if (!got) begin
         checks++;
         errors++;
         $display("FAIL ack_timeout m%0d: got no ack expected ack", m);
         if (m == 0) void'(q0.pop_back());
         else void'(q1.pop_back());
      end
   endtask

   task automatic rand_master(input int m, input int n);
      logic        w, l;
      logic [15:0] a;
      logic [7:0]  d;
      int          lt;
      for (int k = 0; k < n; k++) begin
         repeat ($urandom_range(0, 3)) @(negedge clk);
         w = 1'($urandom_range(0, 1));
         l = ($urandom_range(0, 3) == 0);
         a = ((m == 0) ? 16'h0040 : 16'h8080) + 16'($urandom_range(0, 15));
         d = 8'($urandom);
         xfer(m, w, l, a, d, lt);
      end
   endtask

   task automatic check_order(input string n, input int ex[$]);
      check_eq({n, "_count"}, 64'(hist_m.size()), 64'(ex.size()));
      for (int i = 0; i < ex.size() && i < hist_m.size(); i++) begin
         check_eq($sformatf("%s_grant%0d", n, i),
                  64'(hist_m[i]), 64'(ex[i]));
      end
   endtask

   // monitor: invariants every cycle, scoreboard pop on every ack
   initial begin
      logic        pv_stb, pv_we;
      logic [15:0] pv_adr;
      logic [7:0]  pv_dat;
      logic [7:0]  held [2];
      int          m;
      exp_t        e;
      bit          have;
      pv_stb = 1'b0; pv_we = 1'b0; pv_adr = '0; pv_dat = '0;
      held[0] = '0; held[1] = '0;
      ackcnt[0] = 0; ackcnt[1] = 0;
      forever begin
         @(negedge clk);
         if (in_rst) begin
            check_eq("reset_outputs",
                     64'({m0_ack, m1_ack, aux_we, aux_re, aux_adr,
                          aux_wd, m0_rd, m1_rd}), 64'(0));
            held[0] = '0;
            held[1] = '0;
            pv_stb  = 1'b0;
         end else begin
            check_eq("strobe_onehot", 64'(aux_we & aux_re), 64'(0));
            check_eq("ack_onehot", 64'(m0_ack & m1_ack), 64'(0));
            if (aux_we | aux_re)
               check_eq("b2b_strobe", 64'(pv_stb), 64'(0));
            if (m0_ack | m1_ack) begin
               m = m1_ack ? 1 : 0;
               ackcnt[m]++;
               hist_m.push_back(m);
               hist_c.push_back(cyc);
               check_eq("ack_after_strobe", 64'(pv_stb), 64'(1));
               have = (m == 0) ? (q0.size() > 0) : (q1.size() > 0);
               if (!have) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_ack m%0d: got ack expected none", m);
               end else begin
                  e = (m == 0) ? q0.pop_front() : q1.pop_front();
                  check_eq($sformatf("m%0d_bus_we", m), 64'(pv_we), 64'(e.we));
                  check_eq($sformatf("m%0d_bus_adr", m), 64'(pv_adr), 64'(e.adr));
                  if (e.we)
                     check_eq($sformatf("m%0d_bus_dat", m), 64'(pv_dat), 64'(e.dat));
                  else
                     held[m] = e.rd;
               end
            end
            check_eq("m0_dat_o", 64'(m0_rd), 64'(held[0]));
            check_eq("m1_dat_o", 64'(m1_rd), 64'(held[1]));
            pv_stb = aux_we | aux_re;
            pv_we  = aux_we;
            pv_adr = aux_adr;
            pv_dat = aux_wd;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int l0, l1, a0;
      reset_i = 1'b1;
      mem_clr = 1'b1;
      for (int i = 0; i < 2; i++) begin
         req[i] = 1'b0; we[i] = 1'b0; lck[i] = 1'b0;
         adr[i] = '0; wdat[i] = '0;
      end
      repeat (3) @(negedge clk);
      reset_i = 1'b0;
      mem_clr = 1'b0;
      @(negedge clk);

      // single write, then cross-master read of it
      xfer(0, 1'b1, 1'b0, 16'h1234, 8'hA5, l0);
      check_eq("t1_latency", 64'(l0), 64'(2));
      @(negedge clk);
      xfer(1, 1'b0, 1'b0, 16'h1234, 8'h00, l1);
      check_eq("t2_latency", 64'(l1), 64'(2));
      repeat (4) @(negedge clk);
      check_eq("t2_hold", 64'(m1_rd), 64'(8'hA5));

      // both requesting from reset: strict alternation, 3-cycle spacing
      reset_i = 1'b1;
      repeat (2) @(negedge clk);
      reset_i = 1'b0;
      hist_m.delete();
      hist_c.delete();
      fork
         begin
            for (int k = 0; k < 3; k++)
               xfer(0, 1'b1, 1'b0, 16'h0040 + 16'(k), 8'h10 + 8'(k), l0);
         end
         begin
            for (int k = 0; k < 3; k++)
               xfer(1, 1'b1, 1'b0, 16'h8080 + 16'(k), 8'h20 + 8'(k), l1);
         end
      join
      check_order("t3", exp_t3);
      for (int i = 1; i < hist_c.size(); i++)
         check_eq($sformatf("t3_gap%0d", i),
                  64'(hist_c[i] - hist_c[i-1]), 64'(3));

      // bounded lock: four m0 transfers, then m1 gets in
      @(negedge clk);
      reset_i = 1'b1;
      repeat (2) @(negedge clk);
      reset_i = 1'b0;
      hist_m.delete();
      hist_c.delete();
      fork
         begin
            for (int k = 0; k < 5; k++)
               xfer(0, 1'b1, 1'b1, 16'h0048 + 16'(k), 8'h30 + 8'(k), l0);
         end
         begin
            for (int k = 0; k < 2; k++)
               xfer(1, 1'b1, 1'b0, 16'h8088 + 16'(k), 8'h40 + 8'(k), l1);
         end
      join
      check_order("t4", exp_t4);

      // request dropped and inputs changed right after grant
      repeat (3) @(negedge clk);
      a0 = ackcnt[0];
      push_exp(0, 1'b1, 16'h1235, 8'h3C);
      req[0] = 1'b1; we[0] = 1'b1; lck[0] = 1'b0;
      adr[0] = 16'h1235; wdat[0] = 8'h3C;
      @(negedge clk);
      check_eq("t5_strobe", 64'(aux_we), 64'(1));
      req[0] = 1'b0; we[0] = 1'b0; adr[0] = 16'hFFFF; wdat[0] = 8'h00;
      repeat (8) @(negedge clk);
      check_eq("t5_ack_count", 64'(ackcnt[0] - a0), 64'(1));

      // reset during XFER aborts; afterwards m0 wins the first tie
      req[1] = 1'b1; we[1] = 1'b0; lck[1] = 1'b0; adr[1] = 16'h1234;
      @(negedge clk);
      check_eq("t6_in_xfer", 64'(aux_re), 64'(1));
      reset_i = 1'b1;
      req[1]  = 1'b0;
      repeat (3) @(negedge clk);
      reset_i = 1'b0;
      hist_m.delete();
      hist_c.delete();
      fork
         xfer(0, 1'b0, 1'b0, 16'h1234, 8'h00, l0);
         xfer(1, 1'b0, 1'b0, 16'h1235, 8'h00, l1);
      join
      check_order("t6", exp_t6);

      // randomized concurrent traffic with random locks and gaps
      @(negedge clk);
      fork
         rand_master(0, 40);
         rand_master(1, 40);
      join
      repeat (6) @(negedge clk);
      check_eq("queues_drained", 64'(q0.size() + q1.size()), 64'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
